// File: rtl/fwd_pkg.sv
// -----------------------------------------------------------------------------
// fwd_pkg
// Shared constants for the forwarding / hazard unit:
//   LAT_ALU, LAT_LOAD : producer latencies (bubbles before a result can be
//                       forwarded from M or W)
//   REG_ZERO          : architectural zero register, never tracked or forwarded
//   chan_lo()         : low bit of channel k inside a packed per-channel bus
// -----------------------------------------------------------------------------
package fwd_pkg;

  localparam int unsigned LAT_ALU  = 32'd0;
  localparam int unsigned LAT_LOAD = 32'd1;
  localparam int unsigned REG_ZERO = 32'd0;

  // Low bit index of channel k in a bus packed as channel k at [k*w +: w].
  function automatic int unsigned chan_lo(input int unsigned k, input int unsigned w);
    return k * w;
  endfunction

endpackage

// File: rtl/fwd_mux_chan.sv
// -----------------------------------------------------------------------------
// fwd_mux_chan
// Bypass selection for one X-stage source operand. M has priority over W
// because it holds the younger producer of the same register.
// Ports:
//   src_addr, src_en        : X-stage source register and its use flag
//   m_wen, m_dst_addr       : M-stage write
//   m_data                  : M-stage result (byte-load merge already applied)
//   w_wen, w_dst_addr       : W-stage write
//   w_data                  : W-stage result
//   sel                     : operand must be taken from data
//   data                    : bypass value (w_data when sel is low)
// -----------------------------------------------------------------------------
import fwd_pkg::*;

module fwd_mux_chan #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned AW     = 4
) (
  input  logic [AW-1:0]     src_addr,
  input  logic              src_en,
  input  logic              m_wen,
  input  logic [AW-1:0]     m_dst_addr,
  input  logic [DATA_W-1:0] m_data,
  input  logic              w_wen,
  input  logic [AW-1:0]     w_dst_addr,
  input  logic [DATA_W-1:0] w_data,
  output logic              sel,
  output logic [DATA_W-1:0] data
);

  logic src_live;
  logic m_hit;
  logic w_hit;

  // Match the source against M and W and pick the younger producer.
  always_comb begin
    src_live = src_en & (src_addr != AW'(REG_ZERO));
    m_hit    = src_live & m_wen & (src_addr == m_dst_addr);
    w_hit    = src_live & w_wen & (src_addr == w_dst_addr);
    sel      = m_hit | w_hit;
    if (m_hit) begin
      data = m_data;
    end else begin
      data = w_data;
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// -----------------------------------------------------------------------------
// fwd_hazard_unit
// Operand forwarding, load-use / long-latency stall generation and store-data
// forwarding for an ID/X/M/W pipeline.
// A per-register countdown scoreboard holds ID until every source it reads has
// reached a forwardable stage; NSRC channels then select M or W bypass data.
// Optional build macro: FWD_PERF_CNT_EN (stall and forward-event counters).
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   freeze                   : global pipeline freeze, no stage advances
//   id_valid, id_src_addr, id_src_en, id_wen, id_dst_addr, id_lat : ID stage
//   id_stall                 : hold ID/PC, inject bubble into X
//   x_src_addr, x_src_en     : X-stage operands
//   m_wen, m_dst_addr, m_alu_out, m_lb, m_lb_val, m_sw, m_rt_addr : M stage
//   w_wen, w_dst_addr, w_data: writeback
//   fwd_sel, fwd_data        : per-channel operand bypass
//   fwd_mem, fwd_mem_data    : store-data replacement in M
//   perf_stall_cnt, perf_fwd_cnt : event counters (zero without the macro)
// -----------------------------------------------------------------------------
import fwd_pkg::*;

module fwd_hazard_unit #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned AW     = 4,
  parameter int unsigned NSRC   = 2,
  parameter int unsigned CW     = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   freeze,
  input  logic                   id_valid,
  input  logic [NSRC*AW-1:0]     id_src_addr,
  input  logic [NSRC-1:0]        id_src_en,
  input  logic                   id_wen,
  input  logic [AW-1:0]          id_dst_addr,
  input  logic [CW-1:0]          id_lat,
  output logic                   id_stall,
  input  logic [NSRC*AW-1:0]     x_src_addr,
  input  logic [NSRC-1:0]        x_src_en,
  input  logic                   m_wen,
  input  logic [AW-1:0]          m_dst_addr,
  input  logic [DATA_W-1:0]      m_alu_out,
  input  logic                   m_lb,
  input  logic [DATA_W-1:0]      m_lb_val,
  input  logic                   w_wen,
  input  logic [AW-1:0]          w_dst_addr,
  input  logic [DATA_W-1:0]      w_data,
  input  logic                   m_sw,
  input  logic [AW-1:0]          m_rt_addr,
  output logic [NSRC-1:0]        fwd_sel,
  output logic [NSRC*DATA_W-1:0] fwd_data,
  output logic                   fwd_mem,
  output logic [DATA_W-1:0]      fwd_mem_data,
  output logic [31:0]            perf_stall_cnt,
  output logic [31:0]            perf_fwd_cnt
);

  localparam int unsigned NREG = 2 ** AW;

  logic [CW-1:0]     rdy_cnt_q [NREG];
  logic [CW-1:0]     rdy_cnt_d [NREG];
  logic              issue;
  logic [AW-1:0]     id_src;
  logic [DATA_W-1:0] m_data;

  // Stall ID while any source it reads is still counting down.
  always_comb begin
    id_stall = 1'b0;
    id_src   = {AW{1'b0}};
    for (int k = 0; k < NSRC; k++) begin
      id_src = id_src_addr[chan_lo(k, AW) +: AW];
      if (id_src_en[k] && (id_src != AW'(REG_ZERO)) && (rdy_cnt_q[id_src] != {CW{1'b0}})) begin
        id_stall = 1'b1;
      end else begin
        id_stall = id_stall;
      end
    end
    id_stall = id_stall & id_valid;
    issue    = id_valid & ~id_stall & ~freeze;
  end

  // Scoreboard next state: issue load beats the per-cycle decrement.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      if (i == int'(REG_ZERO)) begin
        rdy_cnt_d[i] = {CW{1'b0}};
      end else if (freeze) begin
        rdy_cnt_d[i] = rdy_cnt_q[i];
      end else if (issue && id_wen && (id_dst_addr == AW'(i))) begin
        rdy_cnt_d[i] = id_lat;
      end else if (rdy_cnt_q[i] != {CW{1'b0}}) begin
        rdy_cnt_d[i] = rdy_cnt_q[i] - CW'(1);
      end else begin
        rdy_cnt_d[i] = rdy_cnt_q[i];
      end
    end
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        rdy_cnt_q[i] <= {CW{1'b0}};
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        rdy_cnt_q[i] <= rdy_cnt_d[i];
      end
    end
  end

  // M result seen by the bypass: byte-load ops carry their merged value.
  always_comb begin
    if (m_lb) begin
      m_data = m_lb_val;
    end else begin
      m_data = m_alu_out;
    end
  end

  genvar gk;
  generate
    for (gk = 0; gk < NSRC; gk++) begin : g_chan
      fwd_mux_chan #(
        .DATA_W (DATA_W),
        .AW     (AW)
      ) u_chan (
        .src_addr   (x_src_addr[gk*AW +: AW]),
        .src_en     (x_src_en[gk]),
        .m_wen      (m_wen),
        .m_dst_addr (m_dst_addr),
        .m_data     (m_data),
        .w_wen      (w_wen),
        .w_dst_addr (w_dst_addr),
        .w_data     (w_data),
        .sel        (fwd_sel[gk]),
        .data       (fwd_data[gk*DATA_W +: DATA_W])
      );
    end
  endgenerate

  // Store data in M comes from the instruction currently writing back.
  always_comb begin
    fwd_mem      = m_sw & w_wen & (w_dst_addr == m_rt_addr) & (w_dst_addr != AW'(REG_ZERO));
    fwd_mem_data = w_data;
  end

`ifdef FWD_PERF_CNT_EN
  logic [31:0] perf_stall_cnt_q;
  logic [31:0] perf_stall_cnt_d;
  logic [31:0] perf_fwd_cnt_q;
  logic [31:0] perf_fwd_cnt_d;
  logic [31:0] fwd_events;

  // Count stall cycles and forward events on cycles the pipeline advances.
  always_comb begin
    fwd_events = {31'd0, fwd_mem};
    for (int k = 0; k < NSRC; k++) begin
      fwd_events = fwd_events + {31'd0, fwd_sel[k]};
    end
    if (freeze) begin
      perf_stall_cnt_d = perf_stall_cnt_q;
      perf_fwd_cnt_d   = perf_fwd_cnt_q;
    end else begin
      perf_stall_cnt_d = perf_stall_cnt_q + {31'd0, id_stall};
      perf_fwd_cnt_d   = perf_fwd_cnt_q + fwd_events;
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt_q <= 32'd0;
      perf_fwd_cnt_q   <= 32'd0;
    end else begin
      perf_stall_cnt_q <= perf_stall_cnt_d;
      perf_fwd_cnt_q   <= perf_fwd_cnt_d;
    end
  end

  assign perf_stall_cnt = perf_stall_cnt_q;
  assign perf_fwd_cnt   = perf_fwd_cnt_q;
`else
  assign perf_stall_cnt = 32'd0;
  assign perf_fwd_cnt   = 32'd0;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// -----------------------------------------------------------------------------
// tb_fwd_hazard_unit
// Table-driven checks of the combinational bypass paths, followed by
// hand-written multi-cycle sequences for the scoreboard, freeze, reset and
// the optional performance counters (FWD_PERF_CNT_EN).
// -----------------------------------------------------------------------------
module tb_fwd_hazard_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic        id_valid;
  logic [7:0]  id_src_addr;
  logic [1:0]  id_src_en;
  logic        id_wen;
  logic [3:0]  id_dst_addr;
  logic [1:0]  id_lat;
  logic        id_stall;
  logic [7:0]  x_src_addr;
  logic [1:0]  x_src_en;
  logic        m_wen;
  logic [3:0]  m_dst_addr;
  logic [15:0] m_alu_out;
  logic        m_lb;
  logic [15:0] m_lb_val;
  logic        w_wen;
  logic [3:0]  w_dst_addr;
  logic [15:0] w_data;
  logic        m_sw;
  logic [3:0]  m_rt_addr;
  logic [1:0]  fwd_sel;
  logic [31:0] fwd_data;
  logic        fwd_mem;
  logic [15:0] fwd_mem_data;
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_fwd_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  fwd_hazard_unit #(.DATA_W(16), .AW(4), .NSRC(2), .CW(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .freeze         (freeze),
    .id_valid       (id_valid),
    .id_src_addr    (id_src_addr),
    .id_src_en      (id_src_en),
    .id_wen         (id_wen),
    .id_dst_addr    (id_dst_addr),
    .id_lat         (id_lat),
    .id_stall       (id_stall),
    .x_src_addr     (x_src_addr),
    .x_src_en       (x_src_en),
    .m_wen          (m_wen),
    .m_dst_addr     (m_dst_addr),
    .m_alu_out      (m_alu_out),
    .m_lb           (m_lb),
    .m_lb_val       (m_lb_val),
    .w_wen          (w_wen),
    .w_dst_addr     (w_dst_addr),
    .w_data         (w_data),
    .m_sw           (m_sw),
    .m_rt_addr      (m_rt_addr),
    .fwd_sel        (fwd_sel),
    .fwd_data       (fwd_data),
    .fwd_mem        (fwd_mem),
    .fwd_mem_data   (fwd_mem_data),
    .perf_stall_cnt (perf_stall_cnt),
    .perf_fwd_cnt   (perf_fwd_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  xsrc;
    logic [1:0]  xen;
    logic        mwen;
    logic [3:0]  mdst;
    logic [15:0] malu;
    logic        mlb;
    logic [15:0] mlbv;
    logic        msw;
    logic [3:0]  mrt;
    logic        wwen;
    logic [3:0]  wdst;
    logic [15:0] wdata;
    logic [1:0]  esel;
    logic [15:0] ed0;
    logic [15:0] ed1;
    logic        emem;
    logic [15:0] emd;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic quiet();
    freeze = 1'b0; id_valid = 1'b0; id_src_addr = 8'h00; id_src_en = 2'b00;
    id_wen = 1'b0; id_dst_addr = 4'h0; id_lat = 2'd0;
    x_src_addr = 8'h00; x_src_en = 2'b00;
    m_wen = 1'b0; m_dst_addr = 4'h0; m_alu_out = 16'h0000; m_lb = 1'b0; m_lb_val = 16'h0000;
    w_wen = 1'b0; w_dst_addr = 4'h0; w_data = 16'h0000; m_sw = 1'b0; m_rt_addr = 4'h0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    quiet();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic issue(input logic [3:0] dst, input logic [1:0] lat);
    id_valid = 1'b1; id_wen = 1'b1; id_dst_addr = dst; id_lat = lat; id_src_en = 2'b00;
  endtask

  task automatic read_src(input logic [3:0] src);
    id_valid = 1'b1; id_wen = 1'b0; id_src_addr = {4'h0, src}; id_src_en = 2'b01;
  endtask

  initial begin
    //        xsrc   xen    mwen mdst  malu      mlb  mlbv      msw  mrt   wwen wdst  wdata     esel   ed0       ed1       emem emd
    vecs[0] = '{8'h44, 2'b11, 1'b1, 4'h4, 16'h1234, 1'b0, 16'h0000, 1'b0, 4'h0, 1'b1, 4'h4, 16'h5678, 2'b11, 16'h1234, 16'h1234, 1'b0, 16'h5678};
    vecs[1] = '{8'h05, 2'b11, 1'b1, 4'h5, 16'h1111, 1'b1, 16'hAB00, 1'b0, 4'h0, 1'b0, 4'h0, 16'h2222, 2'b01, 16'hAB00, 16'h2222, 1'b0, 16'h2222};
    vecs[2] = '{8'h00, 2'b11, 1'b1, 4'h0, 16'h3333, 1'b0, 16'h0000, 1'b0, 4'h0, 1'b1, 4'h0, 16'h4444, 2'b00, 16'h4444, 16'h4444, 1'b0, 16'h4444};
    vecs[3] = '{8'h66, 2'b00, 1'b0, 4'h6, 16'h5555, 1'b0, 16'h0000, 1'b1, 4'h6, 1'b1, 4'h6, 16'h00FF, 2'b00, 16'h00FF, 16'h00FF, 1'b1, 16'h00FF};
    vecs[4] = '{8'h00, 2'b00, 1'b0, 4'h0, 16'h5555, 1'b0, 16'h0000, 1'b1, 4'h0, 1'b1, 4'h0, 16'h00FF, 2'b00, 16'h00FF, 16'h00FF, 1'b0, 16'h00FF};
    vecs[5] = '{8'h98, 2'b10, 1'b1, 4'h8, 16'h9999, 1'b0, 16'h0000, 1'b0, 4'h0, 1'b1, 4'h9, 16'h4242, 2'b10, 16'h4242, 16'h4242, 1'b0, 16'h4242};
    vecs[6] = '{8'h44, 2'b00, 1'b1, 4'h4, 16'h1234, 1'b0, 16'h0000, 1'b0, 4'h0, 1'b1, 4'h4, 16'h5678, 2'b00, 16'h5678, 16'h5678, 1'b0, 16'h5678};
    vecs[7] = '{8'h33, 2'b11, 1'b0, 4'h3, 16'h3333, 1'b0, 16'h0000, 1'b0, 4'h0, 1'b1, 4'h3, 16'h7777, 2'b11, 16'h7777, 16'h7777, 1'b0, 16'h7777};
    vecs[8] = '{8'h00, 2'b00, 1'b0, 4'h0, 16'h0000, 1'b0, 16'h0000, 1'b1, 4'h6, 1'b0, 4'h6, 16'h00FF, 2'b00, 16'h00FF, 16'h00FF, 1'b0, 16'h00FF};
    vecs[9] = '{8'h22, 2'b11, 1'b1, 4'h2, 16'h0102, 1'b0, 16'hFFFF, 1'b1, 4'h2, 1'b1, 4'h2, 16'hAAAA, 2'b11, 16'h0102, 16'h0102, 1'b1, 16'hAAAA};

    quiet();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("reset id_stall", {31'd0, id_stall}, 32'd0);
    check("reset perf_stall", perf_stall_cnt, 32'd0);
    check("reset perf_fwd", perf_fwd_cnt, 32'd0);

    // Combinational bypass table.
    for (int i = 0; i < 10; i++) begin
      x_src_addr = vecs[i].xsrc; x_src_en = vecs[i].xen;
      m_wen = vecs[i].mwen; m_dst_addr = vecs[i].mdst; m_alu_out = vecs[i].malu;
      m_lb = vecs[i].mlb; m_lb_val = vecs[i].mlbv; m_sw = vecs[i].msw; m_rt_addr = vecs[i].mrt;
      w_wen = vecs[i].wwen; w_dst_addr = vecs[i].wdst; w_data = vecs[i].wdata;
      #1;
      check($sformatf("vec%0d fwd_sel", i), {30'd0, fwd_sel}, {30'd0, vecs[i].esel});
      check($sformatf("vec%0d fwd_data0", i), {16'd0, fwd_data[15:0]}, {16'd0, vecs[i].ed0});
      check($sformatf("vec%0d fwd_data1", i), {16'd0, fwd_data[31:16]}, {16'd0, vecs[i].ed1});
      check($sformatf("vec%0d fwd_mem", i), {31'd0, fwd_mem}, {31'd0, vecs[i].emem});
      check($sformatf("vec%0d fwd_mem_data", i), {16'd0, fwd_mem_data}, {16'd0, vecs[i].emd});
    end

    // Load-use then dual ALU forward, with counters from a clean reset.
    do_reset();
    issue(4'h3, 2'd1);
    #1;
    check("ld issue stall", {31'd0, id_stall}, 32'd0);
    tick();
    read_src(4'h3);
    #1;
    check("ld-use stall c1", {31'd0, id_stall}, 32'd1);
    tick();
    check("ld-use stall c2", {31'd0, id_stall}, 32'd0);
    tick();
    quiet();
    x_src_addr = 8'h03; x_src_en = 2'b01; w_wen = 1'b1; w_dst_addr = 4'h3; w_data = 16'hBEEF;
    #1;
    check("ld-use fwd_sel", {30'd0, fwd_sel}, 32'd1);
    check("ld-use fwd_data0", {16'd0, fwd_data[15:0]}, 32'h0000BEEF);
    tick();
    quiet();
    x_src_addr = 8'h44; x_src_en = 2'b11; m_wen = 1'b1; m_dst_addr = 4'h4; m_alu_out = 16'h1234;
    w_wen = 1'b1; w_dst_addr = 4'h4; w_data = 16'h5678;
    #1;
    check("alu fwd_sel", {30'd0, fwd_sel}, 32'd3);
    check("alu fwd_data", fwd_data, 32'h12341234);
    tick();
    quiet();
    #1;
`ifdef FWD_PERF_CNT_EN
    check("perf_stall_cnt", perf_stall_cnt, 32'd1);
    check("perf_fwd_cnt", perf_fwd_cnt, 32'd3);
`else
    check("perf_stall_cnt off", perf_stall_cnt, 32'd0);
    check("perf_fwd_cnt off", perf_fwd_cnt, 32'd0);
`endif

    // Load followed by a 3-cycle freeze while ID waits on it.
    do_reset();
    issue(4'h7, 2'd1);
    tick();
    read_src(4'h7);
    freeze = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("freeze stall c%0d", c), {31'd0, id_stall}, 32'd1);
      tick();
    end
    freeze = 1'b0;
    #1;
    check("post-freeze stall", {31'd0, id_stall}, 32'd1);
    tick();
    check("post-freeze release", {31'd0, id_stall}, 32'd0);

    // Reset while stalled clears the scoreboard.
    do_reset();
    issue(4'h7, 2'd3);
    tick();
    read_src(4'h7);
    #1;
    check("pre-rst stall", {31'd0, id_stall}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("post-rst stall", {31'd0, id_stall}, 32'd0);

    // Longest latency holds ID exactly three cycles.
    do_reset();
    issue(4'hA, 2'd3);
    tick();
    read_src(4'hA);
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("lat3 stall c%0d", c), {31'd0, id_stall}, 32'd1);
      tick();
    end
    check("lat3 release", {31'd0, id_stall}, 32'd0);

    // Reissue to an entry as it would decrement: the new latency wins.
    do_reset();
    issue(4'hB, 2'd1);
    tick();
    issue(4'hB, 2'd3);
    tick();
    read_src(4'hB);
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("reissue stall c%0d", c), {31'd0, id_stall}, 32'd1);
      tick();
    end
    check("reissue release", {31'd0, id_stall}, 32'd0);

    // ALU latency, r0 destination, invalid ID and frozen issue never stall.
    do_reset();
    issue(4'hC, 2'd0);
    tick();
    read_src(4'hC);
    #1;
    check("alu no stall", {31'd0, id_stall}, 32'd0);
    tick();
    issue(4'h0, 2'd3);
    tick();
    read_src(4'h0);
    #1;
    check("r0 no stall", {31'd0, id_stall}, 32'd0);
    tick();
    issue(4'hD, 2'd3);
    tick();
    read_src(4'hD);
    id_valid = 1'b0;
    #1;
    check("invalid id no stall", {31'd0, id_stall}, 32'd0);
    id_valid = 1'b1;
    id_src_en = 2'b10;
    id_src_addr = 8'hD0;
    #1;
    check("ch1 stall", {31'd0, id_stall}, 32'd1);
    do_reset();
    freeze = 1'b1;
    issue(4'h8, 2'd2);
    tick();
    freeze = 1'b0;
    read_src(4'h8);
    #1;
    check("frozen issue ignored", {31'd0, id_stall}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
